// File: rtl/coin_change_dispenser.sv
// Greedy change dispenser (5/3/1 units): first offer two edges after start; one coin per coinAck rise.
// Outputs come from flops only; an offer waits indefinitely for coinAck, a held coinAck counts as one coin.
module coin_change_dispenser (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       coinAck,
    output logic [1:0] CoinValue,
    output logic       coinValid,
    output logic       busy,
    output logic       done,
    output logic [2:0] coinCount
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_OFFER   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [2:0] count_q, count_d;
    logic [1:0] coin_q, coin_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] pick_code;
    logic [3:0] coin_units;

    // Largest coin that still fits, so remaining can never underflow.
    always_comb begin
        pick_code = 2'b00;
        if (remaining_q >= 4'd5) begin
            pick_code = 2'b11;
        end else if (remaining_q >= 4'd3) begin
            pick_code = 2'b10;
        end else if (remaining_q >= 4'd1) begin
            pick_code = 2'b01;
        end
    end

    always_comb begin
        coin_units = 4'd0;
        case (coin_q)
            2'b01:   coin_units = 4'd1;
            2'b10:   coin_units = 4'd3;
            2'b11:   coin_units = 4'd5;
            default: coin_units = 4'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    count_d     = 3'd0;
                    state_d     = (amount != 4'd0) ? ST_SELECT : ST_DONE;
                end
            end
            ST_SELECT: begin
                state_d = (remaining_q != 4'd0) ? ST_OFFER : ST_DONE;
            end
            ST_OFFER: begin
                if (coinAck) begin
                    remaining_d = remaining_q - coin_units;
                    count_d     = count_q + 3'd1;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!coinAck) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so they line up with state_q.
    always_comb begin
        coin_d  = 2'b00;
        valid_d = (state_d == ST_OFFER);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        if (state_d == ST_OFFER) begin
            coin_d = (state_q == ST_OFFER) ? coin_q : pick_code;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 4'd0;
            count_q     <= 3'd0;
            coin_q      <= 2'b00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            coin_q      <= coin_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign CoinValue = coin_q;
    assign coinValid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign coinCount = count_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser; expected coin sequences come from a greedy reference model.
module tb_coin_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] amount;
    logic       coinAck;
    logic [1:0] CoinValue;
    logic       coinValid;
    logic       busy;
    logic       done;
    logic [2:0] coinCount;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    coin_change_dispenser dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .amount   (amount),
        .coinAck  (coinAck),
        .CoinValue(CoinValue),
        .coinValid(coinValid),
        .busy     (busy),
        .done     (done),
        .coinCount(coinCount)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int units(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b10:   return 3;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    // Reference model: push the greedy coin sequence, return the coin count.
    function automatic int push_expected(input int amt);
        int rem = amt;
        int n   = 0;
        while (rem > 0) begin
            if (rem >= 5) begin exp_q.push_back(2'b11); rem -= 5; end
            else if (rem >= 3) begin exp_q.push_back(2'b10); rem -= 3; end
            else begin exp_q.push_back(2'b01); rem -= 1; end
            n++;
        end
        return n;
    endfunction

    task automatic start_txn(input int amt, output int cnt);
        cnt    = push_expected(amt);
        start  = 1'b1;
        amount = amt[3:0];
        step();
        start  = 1'b0;
        amount = 4'd0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_valid(output bit timed_out);
        int n = 0;
        while (coinValid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        timed_out = (coinValid !== 1'b1);
    endtask

    task automatic serve(input int hold, input bit poke, input int exp_cnt, input int amt);
        int sum = 0;
        int n   = 0;
        bit to;
        logic [1:0] e;
        while (exp_q.size() > 0) begin
            wait_valid(to);
            if (to) begin
                check("offer_timeout", 0, 1);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check("coin_value", CoinValue, e);
            sum += units(CoinValue);
            if (poke) begin
                start  = 1'b1;
                amount = 4'd15;
                poke   = 1'b0;
            end
            coinAck = 1'b1;
            repeat (hold) begin
                step();
                start  = 1'b0;
                amount = 4'd0;
                check("release_no_valid", coinValid, 0);
                check("release_busy", busy, 1);
            end
            coinAck = 1'b0;
        end
        while (done !== 1'b1 && n < 20) begin
            check("early_valid_after_last", coinValid, 0);
            step();
            n++;
        end
        check("done_pulse", done, 1);
        check("done_coinvalue", CoinValue, 0);
        check("done_count", coinCount, exp_cnt);
        check("dispensed_sum", sum, amt);
        step();
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
        check("count_hold", coinCount, exp_cnt);
    endtask

    initial begin
        int cnt;
        bit to;
        reset   = 1'b1;
        start   = 1'b0;
        amount  = 4'd0;
        coinAck = 1'b0;
        step();
        check("rst_coinvalue", CoinValue, 0);
        check("rst_valid", coinValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", coinCount, 0);
        reset = 1'b0;
        step();
        check("idle_no_start", busy, 0);

        // 14 -> 5,5,3,1 with single-cycle acks; also first-offer latency
        start_txn(14, cnt);
        check("lat_select_no_valid", coinValid, 0);
        step();
        check("lat_offer_valid", coinValid, 1);
        serve(1, 1'b0, cnt, 14);
        check("count_max", coinCount, 4);

        // zero amount: done right after the start edge, no offer
        start_txn(0, cnt);
        check("zero_done", done, 1);
        check("zero_no_valid", coinValid, 0);
        serve(1, 1'b0, cnt, 0);
        check("zero_count", coinCount, 0);

        // long acks still count one coin each
        start_txn(2, cnt);
        serve(5, 1'b0, cnt, 2);

        // start/amount while busy are ignored
        start_txn(9, cnt);
        serve(1, 1'b1, cnt, 9);
        step();
        check("poke_stays_idle", busy, 0);

        // coinAck during SELECT is ignored
        start_txn(7, cnt);
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        check("select_ack_valid", coinValid, 1);
        check("select_ack_coin", CoinValue, 2'b11);
        serve(1, 1'b0, cnt, 7);

        // async reset in OFFER, then a fresh transaction
        start_txn(13, cnt);
        wait_valid(to);
        check("pre_reset_valid", coinValid, 1);
        #1 reset = 1'b1;
        #1;
        check("async_valid", coinValid, 0);
        check("async_coinvalue", CoinValue, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_count", coinCount, 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        repeat (3) begin
            step();
            check("no_done_after_reset", done, 0);
            check("idle_after_reset", busy, 0);
        end
        start_txn(1, cnt);
        serve(1, 1'b0, cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
